ram_ctrl_secuenciador: RTL and testbench

//  Synchronous front-end that sits directly upstream of the asynchronous 8-bit RAM.

---
 rtl/ram_ctrl_secuenciador.sv | 190 +++++++++++++++++++
 tb/tb_ram_ctrl_secuenciador.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl_secuenciador.sv
// ram_ctrl_secuenciador: synchronous sequencer in front of an asynchronous single-port RAM.
// Accepts one read/write request at a time over a valid/ready handshake. It drives the RAM
// pins in order (address setup, write-enable pulse, address hold, read settle) and returns
// the result over a valid/ready response channel. Every output comes straight from a flop.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_addr, req_wdata      request payload (1 = write)
//   resp_valid/resp_ready            response handshake
//   resp_rdata, resp_err             read data, out-of-range / verify-mismatch flag
//   mem_dir, mem_dato_e, mem_en      RAM address, write data, write enable
//   mem_dato_s                       RAM read data
//   op_count                         completed responses, saturating
//
// Optional build macro: RAM_WR_VERIFY_EN adds a read-back check after every write.
module ram_ctrl_secuenciador #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned DEPTH    = 11,
  parameter int unsigned WR_PULSE = 1,
  parameter int unsigned RD_WAIT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_dir,
  output logic [DW-1:0] mem_dato_e,
  output logic          mem_en,
  input  logic [DW-1:0] mem_dato_s,
  output logic [15:0]   op_count
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StWrite, StHold, StRead, StResp, StVerify
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          we_q, we_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic [AW-1:0] mem_dir_q, mem_dir_d;
  logic [DW-1:0] mem_dato_e_q, mem_dato_e_d;
  logic          mem_en_q, mem_en_d;
  logic [15:0]   op_count_q, op_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_dir_d    = mem_dir_q;
    mem_dato_e_d = mem_dato_e_q;
    mem_en_d     = 1'b0;
    op_count_d   = op_count_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          we_d = req_we;
          if (32'(req_addr) >= DEPTH) begin
            // Rejected: skip the RAM entirely; resp_valid rises one cycle later in StResp.
            state_d      = StResp;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d      = StSetup;
            mem_dir_d    = req_addr;
            mem_dato_e_d = req_wdata;
          end
        end
      end
      StSetup: begin
        cnt_d = '0;
        if (we_q) begin
          state_d  = StWrite;
          mem_en_d = 1'b1;
        end else begin
          state_d = StRead;
        end
      end
      StWrite: begin
        if (cnt_q == 16'(WR_PULSE - 1)) begin
          state_d = StHold;
        end else begin
          mem_en_d = 1'b1;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      StHold: begin
`ifdef RAM_WR_VERIFY_EN
        state_d = StVerify;
        cnt_d   = '0;
`else
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
`endif
      end
      StRead: begin
        if (cnt_q == 16'(RD_WAIT - 1)) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_dato_s;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef RAM_WR_VERIFY_EN
      StVerify: begin
        if (cnt_q == 16'(RD_WAIT - 1)) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          // mem_dato_e_q still holds the written word.
          resp_err_d   = (mem_dato_s != mem_dato_e_q);
          resp_rdata_d = (mem_dato_s != mem_dato_e_q) ? mem_dato_s : '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      StResp: begin
        if (!resp_valid_q) begin
          // Only reached on the rejected-address path.
          resp_valid_d = 1'b1;
        end else if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          if (op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_dir_q    <= '0;
      mem_dato_e_q <= '0;
      mem_en_q     <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_dir_q    <= mem_dir_d;
      mem_dato_e_q <= mem_dato_e_d;
      mem_en_q     <= mem_en_d;
      op_count_q   <= op_count_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_dir    = mem_dir_q;
  assign mem_dato_e = mem_dato_e_q;
  assign mem_en     = mem_en_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_ram_ctrl_secuenciador.sv
// Self-checking bench for ram_ctrl_secuenciador: behavioural RAM, transaction-level
// reference model, per-cycle output compare, directed scenarios plus random traffic.
module tb_ram_ctrl_secuenciador;

  localparam int unsigned AW       = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned DEPTH    = 11;
  localparam int unsigned WR_PULSE = 1;
  localparam int unsigned RD_WAIT  = 1;
`ifdef RAM_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam logic [7:0] StuckMask = 8'hFE;  // RAM bit0 stuck at 0 on writes
`else
  localparam bit VERIFY = 1'b0;
  localparam logic [7:0] StuckMask = 8'hFF;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_dir;
  logic [DW-1:0] mem_dato_e;
  logic          mem_en;
  logic [DW-1:0] mem_dato_s;
  logic [15:0]   op_count;

  int errors = 0;
  int checks = 0;

  ram_ctrl_secuenciador #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_dir(mem_dir), .mem_dato_e(mem_dato_e), .mem_en(mem_en),
    .mem_dato_s(mem_dato_s), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    return (i == 10) ? 8'd101 : 8'(90 - 10 * i);
  endfunction

  // Physical asynchronous RAM seen by the DUT.
  logic [7:0] ram [DEPTH];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] = init_val(i);
      ram_loaded = 1'b1;
    end else if (mem_en === 1'b1 && int'(mem_dir) < int'(DEPTH)) begin
      ram[int'(mem_dir)] = mem_dato_e & StuckMask;
    end
  end
  always_comb begin
    mem_dato_s = 8'h00;
    if (int'(mem_dir) < int'(DEPTH)) mem_dato_s = ram[int'(mem_dir)];
  end

  // Reference model: one transaction in flight; k counts edges since acceptance.
  logic [7:0]  ref_ram [DEPTH];
  bit          m_on = 1'b0, m_idle, m_busy, m_rvalid, m_we, m_eaddr;
  int          m_k, m_lat;
  logic [7:0]  m_rd, m_dir;
  bit          m_er;
  logic [15:0] m_opc;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      if (!m_on) for (int i = 0; i < int'(DEPTH); i++) ref_ram[i] = init_val(i);
      m_on = 1'b1; m_idle = 1'b0; m_busy = 1'b0; m_rvalid = 1'b0;
      m_opc = '0; m_dir = '0; m_k = 0; m_we = 1'b0; m_eaddr = 1'b0;
    end else if (m_busy) begin
      if (m_rvalid && resp_ready) begin
        m_rvalid = 1'b0; m_busy = 1'b0; m_idle = 1'b1;
        if (m_opc != 16'hFFFF) m_opc = m_opc + 16'd1;
      end else if (!m_rvalid) begin
        m_k++;
        if (m_k == m_lat) m_rvalid = 1'b1;
      end
    end else if (m_idle && req_valid) begin
      acc_cnt++;
      m_busy = 1'b1; m_idle = 1'b0; m_k = 0;
      m_we = req_we;
      m_eaddr = int'(req_addr) >= int'(DEPTH);
      if (m_eaddr) begin
        m_lat = 1; m_rd = 8'h00; m_er = 1'b1;
      end else begin
        m_dir = req_addr;
        if (req_we) begin
          logic [7:0] stored;
          stored = req_wdata & StuckMask;
          ref_ram[int'(req_addr)] = stored;
          m_lat = int'(WR_PULSE) + 2 + (VERIFY ? int'(RD_WAIT) : 0);
          m_er  = VERIFY && (stored != req_wdata);
          m_rd  = m_er ? stored : 8'h00;
        end else begin
          m_lat = int'(RD_WAIT) + 1;
          m_rd  = ref_ram[int'(req_addr)];
          m_er  = 1'b0;
        end
      end
    end else begin
      m_idle = 1'b1;
    end
  end

  // Per-cycle compare against the model.
  int en_hi = 0;
  always @(negedge clk) begin
    if (m_on) begin
      bit en_exp;
      en_exp = m_busy && m_we && !m_eaddr && m_k >= 1 && m_k <= int'(WR_PULSE);
      if (mem_en === 1'b1) en_hi++;
      chk("req_ready", int'(req_ready), int'(m_idle));
      chk("resp_valid", int'(resp_valid), int'(m_rvalid));
      chk("mem_en", int'(mem_en), int'(en_exp));
      chk("mem_dir", int'(mem_dir), int'(m_dir));
      chk("op_count", int'(op_count), int'(m_opc));
      if (m_rvalid) begin
        chk("resp_rdata", int'(resp_rdata), int'(m_rd));
        chk("resp_err", int'(resp_err), int'(m_er));
      end
    end
  end

  // One request/response; lat = edges from accept edge to resp_valid high.
  task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                     input int hold, input bit poke,
                     output logic [7:0] rd, output logic er, output int lat);
    int n, a0;
    a0 = acc_cnt;
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1; resp_ready = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (acc_cnt == a0 && n < 50);
    req_valid = 1'b0;
    rd = 8'h00; er = 1'b0; lat = -1;
    if (acc_cnt == a0) begin chk("accept_timeout", 0, 1); return; end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (resp_valid !== 1'b1) begin chk("resp_timeout", 0, 1); return; end
    rd = resp_rdata; er = resp_err;
    if (poke) begin req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd1; end
    a0 = acc_cnt;
    repeat (hold) begin @(posedge clk); #1; end
    if (poke) begin
      req_valid = 1'b0;
      chk("stall_no_accept", acc_cnt - a0, 0);
      chk("stall_rdata", int'(resp_rdata), 90);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic er;
    int lat, e0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_op_count", int'(op_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", int'(req_ready), 1);

    // Read addr 3.
    txn(1'b0, 8'd3, 8'h00, 0, 1'b0, rd, er, lat);
    chk("t1_rdata", int'(rd), 60);
    chk("t1_err", int'(er), 0);
    chk("t1_lat", lat, 2);

`ifndef RAM_WR_VERIFY_EN
    // Write then read back addr 5.
    e0 = en_hi;
    txn(1'b1, 8'd5, 8'hA5, 1, 1'b0, rd, er, lat);
    chk("t2_wr_err", int'(er), 0);
    chk("t2_wr_rdata", int'(rd), 0);
    chk("t2_wr_lat", lat, 3);
    chk("t2_en_cycles", en_hi - e0, 1);
    txn(1'b0, 8'd5, 8'h00, 0, 1'b0, rd, er, lat);
    chk("t2_rd_back", int'(rd), 8'hA5);
`endif

    // Last valid and first rejected address.
    txn(1'b0, 8'd10, 8'h00, 0, 1'b0, rd, er, lat);
    chk("t3_rd10", int'(rd), 101);
    chk("t3_err10", int'(er), 0);
    e0 = en_hi;
    txn(1'b1, 8'd11, 8'h5A, 0, 1'b0, rd, er, lat);
    chk("t3_err11", int'(er), 1);
    chk("t3_rdata11", int'(rd), 0);
    chk("t3_lat11", lat, 1);
    chk("t3_no_en", en_hi - e0, 0);

    // Stalled response with a competing request.
    txn(1'b0, 8'd0, 8'h00, 4, 1'b1, rd, er, lat);
    chk("t4_rdata", int'(rd), 90);

    // Reset during WRITE.
    e0 = acc_cnt;
    req_we = 1'b1; req_addr = 8'd2; req_wdata = 8'h33; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5_accepted", acc_cnt - e0, 1);
    @(posedge clk); #1;
    chk("t5_en_in_write", int'(mem_en), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t5_en_after_rst", int'(mem_en), 0);
    chk("t5_no_resp", int'(resp_valid), 0);
    chk("t5_op_count", int'(op_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle", int'(req_ready), 1);

`ifdef RAM_WR_VERIFY_EN
    txn(1'b1, 8'd1, 8'h01, 0, 1'b0, rd, er, lat);
    chk("t6_err_mismatch", int'(er), 1);
    chk("t6_rdata_mismatch", int'(rd), 0);
    chk("t6_lat", lat, int'(WR_PULSE + RD_WAIT) + 2);
    txn(1'b1, 8'd1, 8'h02, 0, 1'b0, rd, er, lat);
    chk("t6_err_match", int'(er), 0);
`endif

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 150; i++) begin
      txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 13)), 8'($urandom),
          int'($urandom_range(0, 3)), 1'b0, rd, er, lat);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
